// File: rtl/flash_avalon_bridge_pkg.sv
// Shared types and default timing for the Avalon-MM to async NOR flash bridge.
// Each 32-bit word maps onto two 16-bit flash half-words; the low half sits at the even address.
package flash_bridge_pkg;

  localparam int FLASH_AW    = 27;
  localparam int DEF_SETUP   = 1;
  localparam int DEF_READ    = 6;
  localparam int DEF_WRITE   = 3;
  localparam int DEF_HOLD    = 1;
  localparam int DEF_RST     = 25;

  typedef enum logic [2:0] {
    RST,
    WAITRDY,
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_t;

  // Bit 0 selects the low half and bit 1 the high half. A read with no lanes enabled fetches the whole word.
  function automatic logic [1:0] half_mask(input logic is_read, input logic [3:0] be);
    logic [1:0] m;
    m = {|be[3:2], |be[1:0]};
    if (is_read && (be == 4'h0)) m = 2'b11;
    return m;
  endfunction

endpackage

// File: rtl/flash_avalon_bridge_if.sv
// Avalon-MM slave bus bundle between the Nios II data master and the flash bridge.
interface flash_avalon_bridge_if
  import flash_bridge_pkg::*;
#(
  parameter int ADDR_W = FLASH_AW - 1
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_read;
  logic              avs_write;
  logic [3:0]        avs_byteenable;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;

  modport slave (
    input  avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    output avs_readdata, avs_waitrequest
  );

  modport master (
    output avs_address, avs_read, avs_write, avs_byteenable, avs_writedata,
    input  avs_readdata, avs_waitrequest
  );
endinterface

// File: rtl/flash_avalon_bridge_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level; it clears to 0, so the flash reads as busy out of reset.
module sync_2ff (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);
  logic r_meta;
  logic r_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;
endmodule

// File: rtl/flash_avalon_bridge.sv
// Avalon-MM slave that turns 32-bit word accesses into one or two asynchronous 16-bit NOR flash cycles.
// Every pin is registered from the next state, so the strobes change cleanly at clock edges.
module flash_avalon_bridge
  import flash_bridge_pkg::*;
#(
  parameter int ADDR_W       = FLASH_AW - 1,
  parameter int SETUP_CYCLES = DEF_SETUP,
  parameter int READ_CYCLES  = DEF_READ,
  parameter int WRITE_CYCLES = DEF_WRITE,
  parameter int HOLD_CYCLES  = DEF_HOLD,
  parameter int RST_CYCLES   = DEF_RST
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  flash_avalon_bridge_if.slave    avs,
  output logic [ADDR_W:0]         flash_a,
  output logic [15:0]             flash_dq_out,
  output logic                    flash_dq_oe,
  input  logic [15:0]             flash_dq_in,
  output logic                    flash_ce_n,
  output logic                    flash_oe_n,
  output logic                    flash_we_n,
  output logic                    flash_adv_n,
  output logic                    flash_clk,
  output logic                    flash_reset_n,
  input  logic                    flash_rdy_bsy_n
);
  localparam int CW = 16;

  state_t            r_state, w_state_next;
  logic [CW-1:0]     r_cnt;
  logic              r_half, w_half_next;
  logic [1:0]        r_mask;
  logic              r_is_read;
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rbuf;
  logic [31:0]       r_readdata;
  logic              r_waitreq, r_ce_n, r_oe_n, r_we_n, r_dq_oe, r_flash_reset_n;
  logic [15:0]       r_dq_out;
  logic [ADDR_W:0]   r_flash_a;

  logic              w_rdy_s;
  logic              w_req;
  logic [1:0]        w_new_mask;
  logic [CW-1:0]     w_access_last;
  logic              w_busy_next;
  logic              w_cur_read;
  logic [ADDR_W-1:0] w_cur_addr;
  logic [31:0]       w_cur_wdata;

  sync_2ff u_rdy_sync (
    .clk (clk_clk),
    .rst (reset_reset),
    .i_d (flash_rdy_bsy_n),
    .o_q (w_rdy_s)
  );

  assign w_req         = avs.avs_read | avs.avs_write;
  assign w_new_mask    = half_mask(avs.avs_read, avs.avs_byteenable);
  assign w_access_last = r_is_read ? CW'(READ_CYCLES - 1) : CW'(WRITE_CYCLES - 1);

  // In IDLE the request has not been latched yet, so the pin registers take it straight off the bus.
  assign w_cur_read  = (r_state == IDLE) ? avs.avs_read      : r_is_read;
  assign w_cur_addr  = (r_state == IDLE) ? avs.avs_address   : r_addr;
  assign w_cur_wdata = (r_state == IDLE) ? avs.avs_writedata : r_wdata;

  always_comb begin
    w_state_next = r_state;
    w_half_next  = r_half;
    case (r_state)
      RST:     if (r_cnt == CW'(RST_CYCLES - 1)) w_state_next = WAITRDY;
      WAITRDY: if (w_rdy_s) w_state_next = IDLE;
      IDLE: begin
        if (w_rdy_s && w_req) begin
          if (w_new_mask == 2'b00) begin
            w_state_next = DONE;
          end else begin
            w_state_next = SETUP;
            w_half_next  = ~w_new_mask[0];
          end
        end
      end
      SETUP:   if (r_cnt == CW'(SETUP_CYCLES - 1)) w_state_next = ACCESS;
      ACCESS:  if (r_cnt == w_access_last) w_state_next = HOLD;
      HOLD: begin
        if (r_cnt == CW'(HOLD_CYCLES - 1)) begin
          if (!r_half && r_mask[1]) begin
            w_state_next = SETUP;
            w_half_next  = 1'b1;
          end else begin
            w_state_next = DONE;
          end
        end
      end
      DONE:    w_state_next = IDLE;
      default: w_state_next = RST;
    endcase
  end

  assign w_busy_next = (w_state_next == SETUP) || (w_state_next == ACCESS) || (w_state_next == HOLD);

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      r_state         <= RST;
      r_cnt           <= '0;
      r_half          <= 1'b0;
      r_mask          <= 2'b00;
      r_is_read       <= 1'b0;
      r_addr          <= '0;
      r_wdata         <= '0;
      r_rbuf          <= '0;
      r_readdata      <= '0;
      r_waitreq       <= 1'b1;
      r_ce_n          <= 1'b1;
      r_oe_n          <= 1'b1;
      r_we_n          <= 1'b1;
      r_dq_oe         <= 1'b0;
      r_dq_out        <= '0;
      r_flash_a       <= '0;
      r_flash_reset_n <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_half  <= w_half_next;
      r_cnt   <= (w_state_next != r_state) ? '0 : r_cnt + 1'b1;

      if ((r_state == IDLE) && (w_state_next != IDLE)) begin
        r_is_read <= avs.avs_read;
        r_addr    <= avs.avs_address;
        r_wdata   <= avs.avs_writedata;
        r_mask    <= w_new_mask;
        r_rbuf    <= '0;
      end

      // Capture on the last strobe cycle; readdata is only replaced once the whole word is in.
      if ((r_state == ACCESS) && (w_state_next == HOLD) && r_is_read) begin
        if (r_half) r_rbuf[31:16] <= flash_dq_in;
        else        r_rbuf[15:0]  <= flash_dq_in;
      end
      if ((r_state == HOLD) && (w_state_next == DONE) && r_is_read) r_readdata <= r_rbuf;

      if (w_state_next == SETUP) begin
        r_flash_a <= {w_cur_addr, w_half_next};
        if (!w_cur_read) r_dq_out <= w_half_next ? w_cur_wdata[31:16] : w_cur_wdata[15:0];
      end

      r_waitreq       <= (w_state_next != DONE);
      r_ce_n          <= ~w_busy_next;
      r_oe_n          <= ~((w_state_next == ACCESS) && w_cur_read);
      r_we_n          <= ~((w_state_next == ACCESS) && !w_cur_read);
      r_dq_oe         <= w_busy_next && !w_cur_read;
      r_flash_reset_n <= (w_state_next != RST);
    end
  end

  assign avs.avs_readdata    = r_readdata;
  assign avs.avs_waitrequest = r_waitreq;
  assign flash_a             = r_flash_a;
  assign flash_dq_out        = r_dq_out;
  assign flash_dq_oe         = r_dq_oe;
  assign flash_ce_n          = r_ce_n;
  assign flash_oe_n          = r_oe_n;
  assign flash_we_n          = r_we_n;
  assign flash_adv_n         = 1'b0;
  assign flash_clk           = 1'b0;
  assign flash_reset_n       = r_flash_reset_n;
endmodule

// File: tb/tb_flash_avalon_bridge.sv
// Directed bench for flash_avalon_bridge: a small flash model plus per-scenario tasks with hand-computed expectations.
module tb_flash_avalon_bridge;

  logic        clk;
  logic        rst;
  logic [26:0] flash_a;
  logic [15:0] flash_dq_out;
  logic        flash_dq_oe;
  logic [15:0] flash_dq_in;
  logic        flash_ce_n, flash_oe_n, flash_we_n, flash_adv_n, flash_clk, flash_reset_n;
  logic        flash_rdy_bsy_n;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [256];

  int m_oe = 0, m_we = 0, m_ce = 0, m_dqoe = 0, m_ovl = 0, m_oep = 0, m_wrn = 0;
  logic [26:0] wr_a [64];
  logic [15:0] wr_d [64];
  logic prev_we = 1'b1;
  logic prev_oe = 1'b1;

  flash_avalon_bridge_if #(.ADDR_W(26)) avs_if ();

  flash_avalon_bridge dut (
    .clk_clk         (clk),
    .reset_reset     (rst),
    .avs             (avs_if),
    .flash_a         (flash_a),
    .flash_dq_out    (flash_dq_out),
    .flash_dq_oe     (flash_dq_oe),
    .flash_dq_in     (flash_dq_in),
    .flash_ce_n      (flash_ce_n),
    .flash_oe_n      (flash_oe_n),
    .flash_we_n      (flash_we_n),
    .flash_adv_n     (flash_adv_n),
    .flash_clk       (flash_clk),
    .flash_reset_n   (flash_reset_n),
    .flash_rdy_bsy_n (flash_rdy_bsy_n)
  );

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  assign flash_dq_in = (!flash_oe_n && !flash_ce_n) ? mem[flash_a[7:0]] : 16'h0000;

  // Pin activity monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!flash_oe_n) m_oe++;
    if (!flash_we_n) m_we++;
    if (!flash_ce_n) m_ce++;
    if (flash_dq_oe) m_dqoe++;
    if (flash_dq_oe && !flash_oe_n) m_ovl++;
    if (!flash_oe_n && prev_oe) m_oep++;
    if (!flash_we_n && prev_we && (m_wrn < 64)) begin
      wr_a[m_wrn] = flash_a;
      wr_d[m_wrn] = flash_dq_out;
      m_wrn++;
    end
    prev_we = flash_we_n;
    prev_oe = flash_oe_n;
  end

  task automatic access(input bit rd, input logic [25:0] a, input logic [3:0] be,
                        input logic [31:0] wd, input bit scramble,
                        output int cyc, output logic [31:0] rdat);
    avs_if.avs_address    = a;
    avs_if.avs_byteenable = be;
    avs_if.avs_writedata  = wd;
    avs_if.avs_read       = rd;
    avs_if.avs_write      = !rd;
    cyc  = 0;
    rdat = 32'h0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (scramble && (cyc == 1)) begin
        avs_if.avs_address    = ~a;
        avs_if.avs_writedata  = ~wd;
        avs_if.avs_byteenable = ~be;
      end
      if (!avs_if.avs_waitrequest) begin
        rdat = avs_if.avs_readdata;
        break;
      end
    end
    avs_if.avs_read  = 1'b0;
    avs_if.avs_write = 1'b0;
    checks++;
    if (avs_if.avs_waitrequest) begin
      errors++;
      $display("FAIL access_timeout: waitrequest=%0b required 0 within 200 cycles", avs_if.avs_waitrequest);
    end
    $display("access rd=%0d addr=%h be=%h wdata=%h cycles=%0d readdata=%h", rd, a, be, wd, cyc, rdat);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (avs_if.avs_waitrequest !== 1'b1) begin errors++; $display("FAIL rst_waitreq: got %b required 1", avs_if.avs_waitrequest); end
    checks++; if (avs_if.avs_readdata !== 32'h0) begin errors++; $display("FAIL rst_readdata: got %h required 0", avs_if.avs_readdata); end
    checks++; if ({flash_ce_n, flash_oe_n, flash_we_n} !== 3'b111) begin errors++; $display("FAIL rst_strobes: got %b required 111", {flash_ce_n, flash_oe_n, flash_we_n}); end
    checks++; if ({flash_dq_oe, flash_dq_out, flash_a} !== 44'h0) begin errors++; $display("FAIL rst_pins: dq_oe=%b dq_out=%h a=%h required 0", flash_dq_oe, flash_dq_out, flash_a); end
    checks++; if ({flash_reset_n, flash_adv_n, flash_clk} !== 3'b000) begin errors++; $display("FAIL rst_const: got %b required 000", {flash_reset_n, flash_adv_n, flash_clk}); end
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (flash_reset_n) break;
    end
    checks++; if (n != 25) begin errors++; $display("FAIL rst_low_cycles: got %0d required 25", n); end
    // Request right as flash_reset_n rises: one WAITRDY cycle, then IDLE accepts.
    avs_if.avs_address = 26'h10; avs_if.avs_byteenable = 4'hF; avs_if.avs_read = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n++;
      if (!flash_ce_n) break;
    end
    checks++; if (n != 2) begin errors++; $display("FAIL first_accept: ce_n low after %0d cycles required 2", n); end
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n++;
      if (!avs_if.avs_waitrequest) break;
    end
    checks++; if (n != 18) begin errors++; $display("FAIL first_read_done: got %0d cycles required 18", n); end
    $display("access rd=1 addr=%h be=f cycles=%0d readdata=%h", 26'h10, n, avs_if.avs_readdata);
    avs_if.avs_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_read();
    int cyc, oe0, oep0, dq0, ce0, ov0;
    logic [31:0] rd;
    oe0 = m_oe; oep0 = m_oep; dq0 = m_dqoe; ce0 = m_ce; ov0 = m_ovl;
    access(1'b1, 26'h10, 4'hF, 32'h0, 1'b0, cyc, rd);
    checks++; if (cyc != 17) begin errors++; $display("FAIL read_latency: got %0d required 17", cyc); end
    checks++; if (rd !== 32'hABCD1234) begin errors++; $display("FAIL read_data: got %h required abcd1234", rd); end
    checks++; if ((m_oe - oe0) != 12 || (m_oep - oep0) != 2) begin errors++; $display("FAIL read_oe: low=%0d pulses=%0d required 12/2", m_oe - oe0, m_oep - oep0); end
    checks++; if ((m_dqoe - dq0) != 0 || (m_ovl - ov0) != 0) begin errors++; $display("FAIL read_dq_oe: dq_oe cycles=%0d overlap=%0d required 0/0", m_dqoe - dq0, m_ovl - ov0); end
    checks++; if ((m_ce - ce0) != 16) begin errors++; $display("FAIL read_ce: got %0d required 16", m_ce - ce0); end
  endtask

  task automatic test_partial_read();
    int cyc;
    logic [31:0] rd;
    access(1'b1, 26'h10, 4'b1100, 32'h0, 1'b0, cyc, rd);
    checks++; if (cyc != 9) begin errors++; $display("FAIL hi_read_latency: got %0d required 9", cyc); end
    checks++; if (rd !== 32'hABCD0000) begin errors++; $display("FAIL hi_read_data: got %h required abcd0000", rd); end
    access(1'b1, 26'h10, 4'b0000, 32'h0, 1'b0, cyc, rd);
    checks++; if (cyc != 17) begin errors++; $display("FAIL be0_read_latency: got %0d required 17", cyc); end
    checks++; if (rd !== 32'hABCD1234) begin errors++; $display("FAIL be0_read_data: got %h required abcd1234", rd); end
  endtask

  task automatic test_write();
    int cyc, we0, wn0, dq0, oe0;
    logic [31:0] rd;
    we0 = m_we; wn0 = m_wrn; dq0 = m_dqoe; oe0 = m_oe;
    access(1'b0, 26'h3, 4'b1100, 32'hBEEF0000, 1'b0, cyc, rd);
    checks++; if (cyc != 6) begin errors++; $display("FAIL wr_hi_latency: got %0d required 6", cyc); end
    checks++; if ((m_wrn - wn0) != 1 || (m_we - we0) != 3) begin errors++; $display("FAIL wr_hi_pulse: pulses=%0d low=%0d required 1/3", m_wrn - wn0, m_we - we0); end
    checks++; if (wr_a[wn0] !== 27'h7 || wr_d[wn0] !== 16'hBEEF) begin errors++; $display("FAIL wr_hi_pins: a=%h d=%h required 7/beef", wr_a[wn0], wr_d[wn0]); end
    checks++; if ((m_dqoe - dq0) != 5 || (m_oe - oe0) != 0) begin errors++; $display("FAIL wr_hi_dq_oe: dq_oe=%0d oe=%0d required 5/0", m_dqoe - dq0, m_oe - oe0); end
    checks++; if (avs_if.avs_readdata !== 32'hABCD1234) begin errors++; $display("FAIL readdata_hold: got %h required abcd1234", avs_if.avs_readdata); end
  endtask

  task automatic test_write_full_scrambled();
    int cyc, wn0, we0;
    logic [31:0] rd;
    wn0 = m_wrn; we0 = m_we;
    access(1'b0, 26'h8, 4'hF, 32'h55AA1234, 1'b1, cyc, rd);
    checks++; if (cyc != 11) begin errors++; $display("FAIL wr_full_latency: got %0d required 11", cyc); end
    checks++; if ((m_wrn - wn0) != 2 || (m_we - we0) != 6) begin errors++; $display("FAIL wr_full_pulses: pulses=%0d low=%0d required 2/6", m_wrn - wn0, m_we - we0); end
    checks++; if (wr_a[wn0] !== 27'h10 || wr_d[wn0] !== 16'h1234) begin errors++; $display("FAIL wr_full_lo: a=%h d=%h required 10/1234", wr_a[wn0], wr_d[wn0]); end
    checks++; if (wr_a[wn0+1] !== 27'h11 || wr_d[wn0+1] !== 16'h55AA) begin errors++; $display("FAIL wr_full_hi: a=%h d=%h required 11/55aa", wr_a[wn0+1], wr_d[wn0+1]); end
  endtask

  task automatic test_write_be0();
    int cyc, ce0;
    logic [31:0] rd;
    ce0 = m_ce;
    access(1'b0, 26'h5, 4'h0, 32'h12345678, 1'b0, cyc, rd);
    checks++; if (cyc != 1) begin errors++; $display("FAIL wr_be0_latency: got %0d required 1", cyc); end
    checks++; if ((m_ce - ce0) != 0) begin errors++; $display("FAIL wr_be0_ce: got %0d ce cycles required 0", m_ce - ce0); end
  endtask

  task automatic test_rdy_block();
    int n, ce0;
    bit seen_low;
    flash_rdy_bsy_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ce0 = m_ce; seen_low = 1'b0;
    avs_if.avs_address = 26'h11; avs_if.avs_byteenable = 4'hF; avs_if.avs_read = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (!avs_if.avs_waitrequest) seen_low = 1'b1;
    end
    checks++; if (seen_low || (m_ce - ce0) != 0) begin errors++; $display("FAIL busy_block: waitreq_low=%0b ce cycles=%0d required 0/0", seen_low, m_ce - ce0); end
    flash_rdy_bsy_n = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n++;
      if (!flash_ce_n) break;
    end
    checks++; if (n != 3) begin errors++; $display("FAIL rdy_start: got %0d cycles required 3", n); end
    flash_rdy_bsy_n = 1'b0;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n++;
      if (!avs_if.avs_waitrequest) break;
    end
    checks++; if (n != 16) begin errors++; $display("FAIL busy_midaccess: got %0d cycles required 16", n); end
    checks++; if (avs_if.avs_readdata !== 32'h9ABC5678) begin errors++; $display("FAIL busy_read_data: got %h required 9abc5678", avs_if.avs_readdata); end
    $display("access rd=1 addr=%h be=f cycles=%0d readdata=%h", 26'h11, n + 3, avs_if.avs_readdata);
    avs_if.avs_read = 1'b0;
    flash_rdy_bsy_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic test_async_reset();
    int n, cyc;
    logic [31:0] rd;
    avs_if.avs_address = 26'h0; avs_if.avs_byteenable = 4'hF;
    avs_if.avs_writedata = 32'hCAFEF00D; avs_if.avs_write = 1'b1;
    n = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      n++;
      if (!flash_we_n) break;
    end
    checks++; if (flash_we_n !== 1'b0) begin errors++; $display("FAIL arst_we_seen: we_n=%b required 0", flash_we_n); end
    #5 rst = 1'b1;
    #1;
    checks++; if ({flash_we_n, flash_dq_oe, avs_if.avs_waitrequest, flash_reset_n} !== 4'b1010) begin errors++; $display("FAIL arst_pins: we_n,dq_oe,waitreq,reset_n=%b required 1010", {flash_we_n, flash_dq_oe, avs_if.avs_waitrequest, flash_reset_n}); end
    checks++; if ({flash_ce_n, avs_if.avs_readdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL arst_ce_rdata: ce_n=%b readdata=%h required 1/0", flash_ce_n, avs_if.avs_readdata); end
    avs_if.avs_write = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      n++;
      if (flash_reset_n) break;
    end
    checks++; if (n != 25) begin errors++; $display("FAIL arst_restart: reset_n low %0d cycles required 25", n); end
    @(posedge clk); #1;
    access(1'b1, 26'h10, 4'hF, 32'h0, 1'b0, cyc, rd);
    checks++; if (cyc != 17 || rd !== 32'hABCD1234) begin errors++; $display("FAIL arst_read: cycles=%0d data=%h required 17/abcd1234", cyc, rd); end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 3);
    mem[8'h20] = 16'h1234;
    mem[8'h21] = 16'hABCD;
    mem[8'h22] = 16'h5678;
    mem[8'h23] = 16'h9ABC;
    rst = 1'b0;
    flash_rdy_bsy_n = 1'b1;
    avs_if.avs_address = '0;
    avs_if.avs_read = 1'b0;
    avs_if.avs_write = 1'b0;
    avs_if.avs_byteenable = 4'h0;
    avs_if.avs_writedata = 32'h0;
    #2;
    test_reset();
    test_read();
    test_partial_read();
    test_write();
    test_write_full_scrambled();
    test_write_be0();
    test_rdy_block();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/flash_avalon_bridge.md
Name: flash_avalon_bridge

Overview:
- Avalon-MM responder (slave) that the soc's Nios II data master reaches through an exported conduit.
- Translates 32-bit word accesses into asynchronous 16-bit parallel NOR flash cycles on the board FLASH_* pins.
- Each 32-bit word is two flash half-words, little-endian: the low half is at the even flash address.
- Sits in the top level beside soc. The top level owns the FLASH_D tristate buffer; this block only exposes dq_out, dq_oe and dq_in.

Parameters:
- ADDR_W, 26: Avalon word-address width; flash half-word address is {address, half}, 27 bits.
- SETUP_CYCLES, 1: address/CE setup before strobe, at least 1.
- READ_CYCLES, 6: OE low duration per half; 120 ns at 50 MHz. At least 1.
- WRITE_CYCLES, 3: WE low duration per half. At least 1.
- HOLD_CYCLES, 1: strobe-high hold before the next phase, at least 1.
- RST_CYCLES, 25: flash_reset_n low time after reset release.

Ports:
- clk_clk  in  1  system clock, 50 MHz.
- reset_reset  in  1  asynchronous, active-high reset.
- avs_address  in  ADDR_W  word address.
- avs_read  in  1  read request, held until waitrequest is low.
- avs_write  in  1  write request, held until waitrequest is low.
- avs_byteenable  in  4  byte lanes.
- avs_writedata  in  32  write data.
- avs_readdata  out  32  read data, valid in the cycle avs_read=1 and avs_waitrequest=0.
- avs_waitrequest  out  1  stall.
- flash_a  out  27  FLASH_A[27:1].
- flash_dq_out  out  16  write data to the pad.
- flash_dq_oe  out  1  pad output enable.
- flash_dq_in  in  16  pad input.
- flash_ce_n, flash_oe_n, flash_we_n  out  1 each  strobes.
- flash_adv_n  out  1  constant 0 (asynchronous mode).
- flash_clk  out  1  constant 0.
- flash_reset_n  out  1  flash reset.
- flash_rdy_bsy_n  in  1  asynchronous ready.

Behaviour:
- Reset values (all registered, applied immediately on async reset, including mid-operation):
  - waitrequest=1, readdata=0
  - ce_n=oe_n=we_n=1, dq_oe=0, dq_out=0, flash_a=0
  - flash_reset_n=0, state=RST
- Ready input: flash_rdy_bsy_n passes through a 2-flop synchroniser to give rdy_s.
- States and transitions:
  - RST: count RST_CYCLES with flash_reset_n=0, then set flash_reset_n=1 and go to WAITRDY.
  - WAITRDY: go to IDLE once rdy_s=1.
  - IDLE: waitrequest=1. If rdy_s=1 and a request is present (read has priority if both are asserted), latch address/byteenable/writedata and the half mask, then go to SETUP, or to DONE if the mask is empty.
  - Read mask: lanes[1:0]→low half, lanes[3:2]→high half. byteenable=0 on a read is treated as 4'hF.
  - Write mask: a half is written in full (16 bits) if any of its bytes is enabled. byteenable=0 on a write completes via DONE with no flash cycle.
  - SETUP: ce_n=0, flash_a={addr,half}. For writes, dq_oe=1 and dq_out=the selected half. Lasts SETUP_CYCLES.
  - ACCESS: oe_n=0 (read) or we_n=0 (write), for READ_CYCLES or WRITE_CYCLES. For reads, flash_dq_in is captured into the selected half of readdata on the last ACCESS cycle; unselected halves hold 0.
  - HOLD: strobes high, ce_n=0, dq_oe still asserted for writes. Lasts HOLD_CYCLES. Then go to SETUP for the next masked half, else to DONE.
  - DONE: waitrequest=0 for exactly 1 cycle; ce_n=1 and dq_oe=0. Next state is IDLE.
- Timing: with a request sampled in IDLE at cycle T, waitrequest=0 at T+1+h·(S+A+H), where h is the number of halves, S=SETUP_CYCLES, A=READ_CYCLES or WRITE_CYCLES, H=HOLD_CYCLES.
  - Defaults, full read: T+17.
  - Defaults, full write: T+11.
- dq_oe and oe_n are never both active in the same cycle.
- readdata holds its value until the next read completes.
- Changes to avs_* inputs during an access are ignored; the latched copies are used.
- rdy_s falling mid-access does not abort the access; it only blocks acceptance in IDLE.

Decomposition:
- Package flash_bridge_pkg:
  - state enum {RST, WAITRDY, IDLE, SETUP, ACCESS, HOLD, DONE}
  - default timing constants
  - FLASH_AW=27
- One sub-module: sync_2ff, the single-bit 2-flop synchroniser used for rdy_bsy_n.

Test Plan:
- Reset release with rdy_bsy_n=1 → flash_reset_n low for 25 cycles, then high; first read is accepted no earlier than 2 cycles after that.
- Read addr 0x000010, be=4'hF, flash model returns 0x1234 at 0x20 and 0xABCD at 0x21 → readdata=0xABCD1234, waitrequest low at T+17, OE low 6 cycles per half, dq_oe=0 throughout.
- Write addr 0x3, be=4'b1100, data=0xBEEF0000 → one WE pulse of 3 cycles at flash_a=0x7 with dq_out=0xBEEF; waitrequest low at T+6.
- Write with be=0 → no ce_n activity; waitrequest low at T+1.
- Hold rdy_bsy_n=0 and issue a read → waitrequest stays 1 and ce_n stays 1. Raise rdy_bsy_n → the access starts 3 cycles later.
- Assert reset_reset in the middle of ACCESS of a write → we_n=1, dq_oe=0, waitrequest=1 in the same cycle (asynchronous), flash_reset_n=0; the sequence restarts at RST.
